// File: rtl/i2c_master_writer.sv
// I2C master transmitter for single-register writes: START, address+W, register
// address, data byte, STOP, with open-drain SCL/SDA driven through output enables.
module i2c_master_writer #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned CLK_DIV    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_data,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_error
);

  localparam int unsigned         DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_ACK,
    S_STOP,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_q;
  logic [2:0]       r_bit;
  logic [1:0]       r_byte;
  logic [7:0]       r_frame [3];
  logic             r_ack_error;

  logic             w_busy;
  logic             w_accept;
  logic             w_qtick;
  logic             w_phase_end;
  logic [7:0]       w_cur_byte;
  logic             w_bit;

  assign w_busy      = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_accept    = req && !w_busy;
  assign w_qtick     = (r_div == DIV_LAST);
  assign w_phase_end = w_qtick && (r_q == 2'd3);

  always_comb begin
    case (r_byte)
      2'd0:    w_cur_byte = r_frame[0];
      2'd1:    w_cur_byte = r_frame[1];
      default: w_cur_byte = r_frame[2];
    endcase
  end

  assign w_bit = w_cur_byte[r_bit];

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of the others and simulation matches hardware.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: every output of this block gets a default first; a path that skipped
  // an assignment would otherwise infer a latch.
  always_comb begin
    w_next_state = r_state;
    scl_oe       = 1'b0;
    sda_oe       = 1'b0;
    busy         = w_busy;
    done         = (r_state == S_DONE);
    ack_error    = r_ack_error;

    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = S_START;
      end
      S_START: begin
        sda_oe = 1'b1;
        scl_oe = r_q[1];
        if (w_phase_end) w_next_state = S_DATA;
      end
      S_DATA: begin
        scl_oe = ~r_q[1];
        sda_oe = ~w_bit;
        if (w_phase_end && (r_bit == 3'd0)) w_next_state = S_ACK;
      end
      S_ACK: begin
        scl_oe = ~r_q[1];
        if (w_phase_end) begin
          // A NACK skips whatever bytes are left and closes the frame.
          if (r_ack_error || (r_byte == 2'd2)) w_next_state = S_STOP;
          else                                  w_next_state = S_DATA;
        end
      end
      S_STOP: begin
        scl_oe = ~r_q[1];
        sda_oe = (r_q != 2'd3);
        if (w_phase_end) w_next_state = S_DONE;
      end
      S_DONE: begin
        w_next_state = w_accept ? S_START : S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase

    // Reset releases the bus in the same cycle rather than at the next edge.
    if (rst) begin
      scl_oe    = 1'b0;
      sda_oe    = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      ack_error = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div       <= '0;
      r_q         <= 2'd0;
      r_bit       <= 3'd7;
      r_byte      <= 2'd0;
      r_ack_error <= 1'b0;
    end else if (w_accept) begin
      r_div       <= '0;
      r_q         <= 2'd0;
      r_bit       <= 3'd7;
      r_byte      <= 2'd0;
      r_ack_error <= 1'b0;
    end else if (w_busy) begin
      r_div <= w_qtick ? '0 : r_div + 1'b1;
      if (w_qtick) r_q <= r_q + 2'd1;

      if ((r_state == S_ACK) && (r_q == 2'd2) && w_qtick && sda_in)
        r_ack_error <= 1'b1;

      if (w_phase_end) begin
        case (r_state)
          S_START: begin
            r_bit  <= 3'd7;
            r_byte <= 2'd0;
          end
          S_DATA:  r_bit <= r_bit - 3'd1;
          S_ACK: begin
            r_bit  <= 3'd7;
            r_byte <= r_byte + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: the frame bytes are plain data registers loaded on every accept and
  // never read while idle, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_frame[0] <= {SLAVE_ADDR, 1'b0};
      r_frame[1] <= req_addr;
      r_frame[2] <= req_data;
    end
  end

endmodule

// File: tb/tb_i2c_master_writer.sv
// Directed bench for i2c_master_writer: open-drain bus with a behavioural slave
// that decodes START/STOP/bytes and acknowledges all bytes except a chosen one.
module tb_i2c_master_writer;

  localparam int CLK_DIV = 4;

  logic       clk;
  logic       rst;
  logic       req;
  logic [7:0] req_addr;
  logic [7:0] req_data;
  logic       scl_oe;
  logic       sda_oe;
  logic       busy;
  logic       done;
  logic       ack_error;

  logic       w_scl;
  logic       w_sda;
  logic       slv_drive;

  int checks;
  int failures;

  i2c_master_writer #(.SLAVE_ADDR(7'h50), .CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .sda_in    (w_sda),
    .scl_oe    (scl_oe),
    .sda_oe    (sda_oe),
    .busy      (busy),
    .done      (done),
    .ack_error (ack_error)
  );

  assign w_scl = ~scl_oe;
  assign w_sda = ~sda_oe & slv_drive;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural slave: nack_byte is the frame byte index it refuses (-1 = none).
  int         nack_byte;
  int         start_cnt, stop_cnt, byte_cnt, bits, frame_byte;
  logic [7:0] shreg;
  logic [7:0] rx [64];
  logic       prev_scl, prev_sda;

  always @(negedge clk) begin
    if (rst) begin
      start_cnt  = 0;
      stop_cnt   = 0;
      byte_cnt   = 0;
      bits       = 0;
      frame_byte = 0;
      shreg      = 8'h00;
      slv_drive  = 1'b1;
      prev_scl   = 1'b1;
      prev_sda   = 1'b1;
    end else begin
      if (prev_scl && w_scl && prev_sda && !w_sda) begin
        start_cnt++;
        bits       = 0;
        frame_byte = 0;
        slv_drive  = 1'b1;
      end else if (prev_scl && w_scl && !prev_sda && w_sda) begin
        stop_cnt++;
      end else if (!prev_scl && w_scl) begin
        if (bits < 8) begin
          shreg = {shreg[6:0], w_sda};
          bits++;
          if (bits == 8) begin
            rx[byte_cnt % 64] = shreg;
            byte_cnt++;
          end
        end else begin
          bits = 0;
          frame_byte++;
        end
      end else if (prev_scl && !w_scl) begin
        slv_drive = !((bits == 8) && (frame_byte != nack_byte));
      end
      prev_scl = w_scl;
      prev_sda = w_sda;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         nack_byte;
    int         exp_done;
    logic       exp_err;
    int         exp_bytes;
  } vec_t;

  vec_t vecs [6];

  // Issues one request and checks the whole frame; cycle 1 is the cycle after accept.
  task automatic run_vec(input int idx, input vec_t v);
    int         done_cyc, b0, s0, p0;
    logic       busy_ok;
    logic [7:0] exp_b;
    b0        = byte_cnt;
    s0        = start_cnt;
    p0        = stop_cnt;
    nack_byte = v.nack_byte;
    req_addr  = v.addr;
    req_data  = v.data;
    req       = 1'b1;
    tick();
    req      = 1'b0;
    req_addr = ~v.addr;
    req_data = ~v.data;
    check($sformatf("v%0d_ack_err_clear", idx), {31'd0, ack_error}, 0);
    done_cyc = -1;
    busy_ok  = 1'b1;
    for (int n = 1; n <= 1000; n++) begin
      if (done === 1'b1) begin
        done_cyc = n;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      req = (n == 50);
      tick();
    end
    req = 1'b0;
    check($sformatf("v%0d_done_cycle", idx), done_cyc, v.exp_done);
    check($sformatf("v%0d_busy_during", idx), {31'd0, busy_ok}, 1);
    check($sformatf("v%0d_busy_at_done", idx), {31'd0, busy}, 0);
    check($sformatf("v%0d_ack_error", idx), {31'd0, ack_error}, {31'd0, v.exp_err});
    check($sformatf("v%0d_bytes_seen", idx), byte_cnt - b0, v.exp_bytes);
    check($sformatf("v%0d_start_cnt", idx), start_cnt - s0, 1);
    check($sformatf("v%0d_stop_cnt", idx), stop_cnt - p0, 1);
    for (int i = 0; i < v.exp_bytes; i++) begin
      exp_b = (i == 0) ? 8'hA0 : (i == 1) ? v.addr : v.data;
      check($sformatf("v%0d_byte%0d", idx, i), {24'd0, rx[(b0 + i) % 64]}, {24'd0, exp_b});
    end
    repeat (3) tick();
    check($sformatf("v%0d_idle_sticky", idx), {27'd0, ack_error, busy, done, scl_oe, sda_oe},
          {27'd0, v.exp_err, 4'b0000});
  endtask

  initial begin
    int dcount, d1, d2, s0, b0, stray_done;
    logic stray_busy;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    req       = 1'b0;
    req_addr  = 8'h00;
    req_data  = 8'h00;
    nack_byte = -1;

    vecs[0] = '{8'h03, 8'h5A, -1, 465, 1'b0, 3};
    vecs[1] = '{8'h03, 8'h5A,  0, 177, 1'b1, 1};
    vecs[2] = '{8'h03, 8'h5A,  2, 465, 1'b1, 3};
    vecs[3] = '{8'h81, 8'h3C,  1, 321, 1'b1, 2};
    vecs[4] = '{8'hFF, 8'h00, -1, 465, 1'b0, 3};
    vecs[5] = '{8'h00, 8'hFF, -1, 465, 1'b0, 3};

    repeat (3) tick();
    check("reset_during", {27'd0, scl_oe, sda_oe, busy, done, ack_error}, 0);
    rst = 1'b0;
    tick();
    check("reset_after", {27'd0, scl_oe, sda_oe, busy, done, ack_error}, 0);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // req held high: second frame accepted in the done cycle, START on cycle 466.
    s0 = start_cnt;
    b0 = byte_cnt;
    nack_byte = -1;
    req_addr = 8'h10;
    req_data = 8'h20;
    req = 1'b1;
    tick();
    dcount = 0;
    d1 = -1;
    d2 = -1;
    for (int n = 1; n <= 1200; n++) begin
      if (done === 1'b1) begin
        dcount++;
        if (dcount == 1) d1 = n;
        else d2 = n;
      end
      if (n == 466) begin
        check("b2b_start_466", {29'd0, busy, scl_oe, sda_oe}, 3'b101);
        req = 1'b0;
      end
      tick();
    end
    check("b2b_done_count", dcount, 2);
    check("b2b_done1", d1, 465);
    check("b2b_done2", d2, 930);
    check("b2b_starts", start_cnt - s0, 2);
    check("b2b_bytes", byte_cnt - b0, 6);

    // Reset mid-frame at cycle 200.
    req_addr = 8'h11;
    req_data = 8'h22;
    req = 1'b1;
    tick();
    req = 1'b0;
    repeat (199) tick();
    check("midframe_busy", {31'd0, busy}, 1);
    rst = 1'b1;
    #1;
    check("midrst_during", {28'd0, scl_oe, sda_oe, busy, done}, 0);
    tick();
    rst = 1'b0;
    check("midrst_after", {28'd0, scl_oe, sda_oe, busy, done}, 0);
    stray_done = 0;
    stray_busy = 1'b0;
    for (int n = 0; n < 600; n++) begin
      tick();
      if (done === 1'b1) stray_done++;
      if (busy !== 1'b0) stray_busy = 1'b1;
    end
    check("midrst_no_done", stray_done, 0);
    check("midrst_stays_idle", {31'd0, stray_busy}, 0);
    run_vec(6, vecs[0]);

    // req together with rst: reset wins and the request is dropped.
    rst = 1'b1;
    req = 1'b1;
    tick();
    rst = 1'b0;
    req = 1'b0;
    check("rst_wins_req", {31'd0, busy}, 0);
    tick();
    check("rst_wins_req_next", {30'd0, busy, scl_oe | sda_oe}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
